div_seq: RTL and testbench
==========================

# div_seq

Multi-cycle sequencer for RV32M division (DIV, DIVU, REM, REMU) in the pipelined core's execute stage. It accepts one operand pair from the ALU operand bus and runs a radix-2 restoring divide over 32 iteration cycles. While it runs it drives a stall request to the hazard unit, then presents the quotient or remainder for exactly one cycle. It replaces the single-cycle combinational divider path on timing-critical builds. The multiplier and base-ALU paths are unaffected.

## Interface
- DATA_WIDTH, 32, operand/result width; iteration count equals DATA_WIDTH
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; valid only while idle; sampled with operands
- op1  input  DATA_WIDTH  dividend (rs1)
- op2  input  DATA_WIDTH  divisor (rs2)
- div_ctrl  input  3  func3: 100 DIV, 101 DIVU, 110 REM, 111 REMU; bit0 = unsigned, bit1 = remainder
- flush  input  1  abort in-flight op (branch mispredict/trap)
- stall  output  1  combinational stall request to hazard unit
- busy  output  1  registered; high while not IDLE
- valid  output  1  result strobe, one cycle
- result  output  DATA_WIDTH  quotient or remainder, registered

## Operation
- States: IDLE, CALC, DONE.
- IDLE, start=1: latch |op1| and |op2| (two's-complement magnitude when signed), sign flags, div_ctrl. Clear remainder register. Counter = 0. Go to CALC.
  - With DIV_FASTPATH_EN defined and a special case detected, go straight to DONE.
- CALC, each cycle:
  - Shift {rem, quo} left 1.
  - Trial-subtract divisor from rem; if the result is non-negative, commit it and set quo[0] = 1.
  - Counter increments. At counter == DATA_WIDTH-1 go to DONE.
- DONE: compute the result from the latched flags, then go to IDLE.
  - Quotient sign: negate if signed and op1 sign != op2 sign, except when divisor = 0.
  - Remainder sign: follows the dividend.
- DONE register behaviour: result written; valid=1 for this cycle only. Result holds its value until the next DONE.
- Special cases (RISC-V mandated, both build variants):
  - divisor 0: quotient 0xFFFFFFFF, remainder = op1.
  - Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- stall = (state==IDLE & start) | state==CALC. stall is low in DONE so the pipeline advances and captures result.
- start while busy: ignored.
- flush: any state goes to IDLE next edge. valid is not asserted and result is unchanged. A flush coincident with DONE suppresses valid. flush has priority over start.
- rst: state IDLE; busy 0, valid 0, result 0, counter 0, internal registers 0. rst overrides flush and start.

## Timing
- start at edge N (IDLE) → CALC at N+1 through N+32 → DONE (valid=1) at N+33 → IDLE at N+34.
- Fastpath special case: DONE at N+1.
- stall is high from the start cycle N through N+32 inclusive. Total stall is 33 cycles.
- A back-to-back start is accepted in the IDLE cycle N+34 at earliest.
- Combinational input-to-output path: start → stall only.
- Iteration arithmetic: DATA_WIDTH+1-bit subtractor. Magnitudes are unsigned DATA_WIDTH; |0x80000000| = 0x80000000.

## Configuration
- DIV_FASTPATH_EN defined: divisor==0 and the signed overflow case skip CALC and reach DONE one cycle after start. stall lasts 1 cycle.
- Not defined: every op, special cases included, takes the full 33-cycle sequence. Results are identical.

## Test plan
- DIVU 100/7 (start, div_ctrl=101) → valid at N+33, result 14; stall high for exactly 33 cycles.
- REM -7/2 (op1=0xFFFFFFF9, div_ctrl=110) → result 0xFFFFFFFF (-1). DIV of the same operands → 0xFFFFFFFD (-3).
- DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM of the same → 0. Check valid at N+1 with DIV_FASTPATH_EN and at N+33 without.
- DIVU 5/0 → 0xFFFFFFFF. REMU 5/0 → 5. DIV -5/0 → 0xFFFFFFFF (no sign fixup).
- flush at N+10 → IDLE at N+11, no valid pulse, result retains the previous value. start at N+11 is accepted normally.
- rst asserted mid-CALC → next edge busy=0, valid=0, result=0, stall=0. start pulses while busy are ignored (single valid per accepted op).

Source files
------------

// File: rtl/div_seq_if.sv
// Operand/result bundle between the execute stage and div_seq.
// master = execute stage / hazard side, slave = the divider.
interface div_seq_if #(parameter int DATA_WIDTH = 32);
  logic                  start;
  logic [DATA_WIDTH-1:0] op1;
  logic [DATA_WIDTH-1:0] op2;
  logic [2:0]            div_ctrl;
  logic                  flush;
  logic                  stall;
  logic                  busy;
  logic                  valid;
  logic [DATA_WIDTH-1:0] result;

  modport master (output start, op1, op2, div_ctrl, flush,
                  input  stall, busy, valid, result);
  modport slave  (input  start, op1, op2, div_ctrl, flush,
                  output stall, busy, valid, result);
endinterface

// File: rtl/div_seq.sv
// RV32M radix-2 restoring divider: DATA_WIDTH+1 cycles start->valid; DIV_FASTPATH_EN shortcuts /0 and overflow to 1 cycle.
// No backpressure: stall holds the pipeline while busy, result/valid are presented for exactly one cycle.
module div_seq #(
  parameter int DATA_WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst,
  div_seq_if.slave  bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   rem_q, rem_d;
  logic [W-1:0]   quo_q, quo_d;
  logic [W-1:0]   dvsr_q, dvsr_d;
  logic [W-1:0]   result_q, result_d;
  logic           neg_quo_q, neg_quo_d;
  logic           neg_rem_q, neg_rem_d;
  logic           rem_sel_q, rem_sel_d;
  logic           busy_q, busy_d;
  logic           valid_q, valid_d;

  logic           is_signed, sgn1, sgn2, div_zero, special;
  logic [W-1:0]   mag1, mag2;
  logic [W:0]     rem_sh, trial;
  logic           unused_ctrl;

  // func3[2] is always set for the M-extension divide group
  assign unused_ctrl = bus.div_ctrl[2];

  assign is_signed = ~bus.div_ctrl[0];
  assign sgn1      = is_signed & bus.op1[W-1];
  assign sgn2      = is_signed & bus.op2[W-1];
  assign mag1      = sgn1 ? -bus.op1 : bus.op1;
  assign mag2      = sgn2 ? -bus.op2 : bus.op2;
  assign div_zero  = (bus.op2 == '0);

`ifdef DIV_FASTPATH_EN
  assign special = div_zero |
                   (is_signed & (bus.op1 == {1'b1, {(W-1){1'b0}}}) & (&bus.op2));
`else
  assign special = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    rem_sel_d = rem_sel_q;
    result_d  = result_q;
    // trial[W] is the borrow: remainder never exceeds 2*divisor-1, so W+1 bits suffice
    rem_sh    = {rem_q, quo_q[W-1]};
    trial     = rem_sh - {1'b0, dvsr_q};

    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          rem_d     = '0;
          quo_d     = mag1;
          dvsr_d    = mag2;
          cnt_d     = '0;
          neg_quo_d = (sgn1 ^ sgn2) & ~div_zero;
          neg_rem_d = sgn1;
          rem_sel_d = bus.div_ctrl[1];
          state_d   = CALC;
          if (special) begin
            // magnitudes chosen so the common sign fixup yields the mandated results
            quo_d   = div_zero ? '1   : {1'b1, {(W-1){1'b0}}};
            rem_d   = div_zero ? mag1 : '0;
            state_d = DONE;
          end
        end
      end
      CALC: begin
        rem_d = trial[W] ? rem_sh[W-1:0] : trial[W-1:0];
        quo_d = {quo_q[W-2:0], ~trial[W]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(W-1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (bus.flush) state_d = IDLE;

    // result is registered on entry to DONE so it lines up with valid
    if (state_d == DONE) begin
      result_d = rem_sel_d ? (neg_rem_d ? -rem_d : rem_d)
                           : (neg_quo_d ? -quo_d : quo_d);
    end
    valid_d = (state_d == DONE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      result_q  <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      rem_sel_q <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      result_q  <= result_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      rem_sel_q <= rem_sel_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
    end
  end

  assign bus.stall  = ((state_q == IDLE) & bus.start) | (state_q == CALC);
  assign bus.busy   = busy_q;
  assign bus.valid  = valid_q;
  assign bus.result = result_q;
endmodule

// File: tb/tb_div_seq.sv
// Randomized and directed checks of div_seq against a plain-arithmetic RV32M reference.
module tb_div_seq;
  localparam int W = 32;
`ifdef DIV_FASTPATH_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_seq_if #(.DATA_WIDTH(W)) bus();
  div_seq #(.DATA_WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] last_result = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] c);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (c[0]) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
    return c[1] ? r : q;
  endfunction

  function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
    bit sp;
    sp = (b == 32'd0) || (!c[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    return (FAST && sp) ? 1 : 33;
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] c, input bit noisy);
    logic [31:0] exp_res;
    int          exp_lat;
    int          lat;
    int          stalls;
    exp_res = ref_div(a, b, c);
    exp_lat = ref_lat(a, b, c);
    stalls  = 0;
    bus.op1 = a; bus.op2 = b; bus.div_ctrl = c; bus.start = 1'b1;
    #1;
    if (bus.stall) stalls++;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (lat <= 40 && !bus.valid) begin
      if (bus.stall) stalls++;
      if (noisy) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.op1   = $urandom;
        bus.op2   = $urandom;
      end
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " result"}, bus.result, exp_res);
    check({tag, " stall_cycles"}, stalls, exp_lat);
    check({tag, " busy_in_done"}, {31'd0, bus.busy}, 32'd1);
    @(negedge clk);
    check({tag, " valid_one_cycle"}, {31'd0, bus.valid}, 32'd0);
    check({tag, " idle_after"}, {31'd0, bus.busy}, 32'd0);
    check({tag, " result_hold"}, bus.result, exp_res);
    last_result = exp_res;
  endtask

  // Start an op and advance to the negedge following edge N+k.
  task automatic start_and_run(input logic [31:0] a, input logic [31:0] b,
                               input logic [2:0] c, input int k);
    bus.op1 = a; bus.op2 = b; bus.div_ctrl = c; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (k - 1) @(negedge clk);
  endtask

  initial begin
    logic [31:0] a, b;
    logic [2:0]  c;
    rst = 1'b1;
    bus.start = 1'b0; bus.op1 = '0; bus.op2 = '0; bus.div_ctrl = 3'b101; bus.flush = 1'b0;
    repeat (2) @(negedge clk);
    check("rst busy",   {31'd0, bus.busy},  32'd0);
    check("rst valid",  {31'd0, bus.valid}, 32'd0);
    check("rst result", bus.result,         32'd0);
    check("rst stall",  {31'd0, bus.stall}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_op("divu_100_7",   32'd100,          32'd7,           3'b101, 1'b0);
    do_op("rem_m7_2",     32'hFFFF_FFF9,    32'd2,           3'b110, 1'b0);
    do_op("div_m7_2",     32'hFFFF_FFF9,    32'd2,           3'b100, 1'b0);
    do_op("div_ovf",      32'h8000_0000,    32'hFFFF_FFFF,   3'b100, 1'b0);
    do_op("rem_ovf",      32'h8000_0000,    32'hFFFF_FFFF,   3'b110, 1'b0);
    do_op("divu_5_0",     32'd5,            32'd0,           3'b101, 1'b0);
    do_op("remu_5_0",     32'd5,            32'd0,           3'b111, 1'b0);
    do_op("div_m5_0",     32'hFFFF_FFFB,    32'd0,           3'b100, 1'b0);
    do_op("rem_m5_0",     32'hFFFF_FFFB,    32'd0,           3'b110, 1'b0);
    do_op("divu_max_1",   32'hFFFF_FFFF,    32'd1,           3'b101, 1'b1);

    // flush sampled at edge N+10: idle afterwards, no valid, result untouched
    start_and_run(32'd1000, 32'd3, 3'b101, 9);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush busy",   {31'd0, bus.busy},  32'd0);
    check("flush valid",  {31'd0, bus.valid}, 32'd0);
    check("flush stall",  {31'd0, bus.stall}, 32'd0);
    check("flush result", bus.result,         last_result);
    do_op("after_flush",  32'd1000,         32'd3,           3'b101, 1'b0);

    // flush in the last CALC cycle suppresses the DONE strobe
    start_and_run(32'd77, 32'd5, 3'b111, 32);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_done valid",  {31'd0, bus.valid}, 32'd0);
    check("flush_done busy",   {31'd0, bus.busy},  32'd0);
    check("flush_done result", bus.result,         last_result);

    // reset mid-CALC
    start_and_run(32'd12345, 32'd11, 3'b100, 15);
    rst = 1'b1;
    @(negedge clk);
    check("midrst busy",   {31'd0, bus.busy},  32'd0);
    check("midrst valid",  {31'd0, bus.valid}, 32'd0);
    check("midrst result", bus.result,         32'd0);
    check("midrst stall",  {31'd0, bus.stall}, 32'd0);
    rst = 1'b0;
    last_result = '0;
    @(negedge clk);

    for (int i = 0; i < 24; i++) begin
      c = {1'b1, 2'($urandom_range(0, 3))};
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 300); b = $urandom_range(1, 17); end
        3: b = b >> $urandom_range(8, 31);
        default: ;
      endcase
      if ($urandom_range(0, 1) == 1) b = -b;
      do_op($sformatf("rand%0d", i), a, b, c, 1'(i % 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
